// File: rtl/ov5640_axis_bridge_if.sv
// AXI4-Stream video channel between the OV5640 bridge and the VDMA write port.
interface ov5640_axis_bridge_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/ov5640_axis_bridge.sv
// OV5640 parallel pixel bus to AXI4-Stream video master with frame-aligned overflow dropping.
// Define OV5640_AXIS_STATS_EN to add the frame_cnt/drop_cnt statistics outputs.
module ov5640_axis_bridge #(
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_vsync,
    input  logic                        in_hsync,
    input  logic                        in_active,
    ov5640_axis_bridge_if.master        m_axis,
    output logic                        overflow
`ifdef OV5640_AXIS_STATS_EN
    ,
    output logic [15:0]                 frame_cnt,
    output logic [15:0]                 drop_cnt
`endif
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned WORD_W = DATA_W + 2;
    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StWaitSof, StRun, StDrop} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0] in_data_q;
    logic              in_active_q;
    logic              in_vsync_q;
    logic              in_vsync_d;
    logic              vsync_rise;
    logic              hsync_unused;

    logic [DATA_W-1:0] hold_data;
    logic              hold_sof;
    logic              hold_vld;
    logic              sof_pend;

    logic              push_req;
    logic              push_ok;
    logic              push_tlast;
    logic              drop;
    logic              load;
    logic              pop;
    logic              full;
    logic              empty;

    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic [PTR_W:0]    count;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [WORD_W-1:0] rd_word;

    assign hsync_unused = in_hsync;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_data_q   <= '0;
            in_active_q <= 1'b0;
            in_vsync_q  <= 1'b0;
            in_vsync_d  <= 1'b0;
        end else begin
            in_data_q   <= in_data;
            in_active_q <= in_active;
            in_vsync_q  <= in_vsync;
            in_vsync_d  <= in_vsync_q;
        end
    end

    assign vsync_rise = in_vsync_q & ~in_vsync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StWaitSof;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitSof, StDrop: if (vsync_rise) state_d = StRun;
            StRun:             if (drop) state_d = StDrop;
            default:           state_d = StWaitSof;
        endcase
    end

    // The held pixel is always pushed once the following cycle is seen; a new frame ends the line.
    always_comb begin
        push_req   = (state_q == StRun) & hold_vld;
        push_tlast = ~in_active_q | vsync_rise;
        drop       = push_req & full;
        push_ok    = push_req & ~full;
        load       = (state_q == StRun) & in_active_q & ~drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_sof  <= 1'b0;
            hold_vld  <= 1'b0;
            sof_pend  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (load) begin
                hold_data <= in_data_q;
                hold_sof  <= sof_pend | vsync_rise;
                hold_vld  <= 1'b1;
            end else if (push_req) begin
                hold_vld  <= 1'b0;
            end
            if (load) begin
                sof_pend <= 1'b0;
            end else if (vsync_rise) begin
                sof_pend <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Full is judged on the pre-pop count so a same-cycle pop never rescues a push.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DepthCnt);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = ~empty & m_axis.tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= {hold_sof, push_tlast, hold_data};
        end
    end

    assign rd_word       = mem[rd_ptr_q[PTR_W-1:0]];
    assign m_axis.tvalid = ~empty;
    assign m_axis.tdata  = empty ? '0 : rd_word[DATA_W-1:0];
    assign m_axis.tlast  = ~empty & rd_word[DATA_W];
    assign m_axis.tuser  = ~empty & rd_word[DATA_W+1];

`ifdef OV5640_AXIS_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (pop && m_axis.tuser) frame_cnt <= frame_cnt + 16'd1;
            if (drop) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_ov5640_axis_bridge.sv
// Randomized self-checking bench for ov5640_axis_bridge against a stream-level reference model.
`timescale 1ns/1ps
module tb_ov5640_axis_bridge;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_vsync;
    logic          in_hsync;
    logic          in_active;
    logic          overflow;
`ifdef OV5640_AXIS_STATS_EN
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;
`endif

    ov5640_axis_bridge_if #(.DATA_W(DW)) axis ();

    ov5640_axis_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_vsync  (in_vsync),
        .in_hsync  (in_hsync),
        .in_active (in_active),
        .m_axis    (axis),
        .overflow  (overflow)
`ifdef OV5640_AXIS_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic vs; logic act; logic [DW-1:0] d; logic rdy; } cyc_t;
    typedef struct { logic [DW-1:0] d; logic u; logic l; } beat_t;

    cyc_t  plan[$];
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    cap_frame;
    bit    exp_ovf;
    int    stall_bad;
    int    stall_cnt;
    int    n_cmp = 0;
    int    n_bad = 0;

    // Ready modes: 0 = always ready, 1 = never ready, 2 = alternate 1/0.
    function automatic logic rdy_of(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return (plan.size() % 2) == 0;
    endfunction

    function automatic void add_cyc(input logic vs, input logic act, input int mode);
        cyc_t c;
        c.vs  = vs;
        c.act = act;
        c.d   = DW'($urandom);
        c.rdy = rdy_of(mode);
        plan.push_back(c);
    endfunction

    function automatic void add_idle(input int n, input int mode);
        repeat (n) add_cyc(1'b0, 1'b0, mode);
    endfunction

    function automatic void add_vsync(input int mode);
        repeat (4) add_cyc(1'b1, 1'b0, mode);
        repeat (16) add_cyc(1'b0, 1'b0, mode);
    endfunction

    function automatic void add_line(input int n, input int gap, input int mode);
        repeat (n) add_cyc(1'b0, 1'b1, mode);
        repeat (gap) add_cyc(1'b0, 1'b0, mode);
    endfunction

    function automatic void add_frame(input int lines, input int len, input int gap, input int mode);
        add_vsync(mode);
        repeat (lines) add_line(len, gap, mode);
    endfunction

    // Frames open on a vsync rise; a pixel is last-of-line when the next cycle is idle or a
    // new frame starts. The capped frame keeps only DEPTH pixels (FIFO filled with no drain).
    function automatic void build_expected();
        bit prev_vs = 0, prev_emit = 0, open = 0, sof = 0;
        bit rise, was_open, emit;
        int fidx = -1, kept = 0;
        foreach (plan[i]) begin
            rise     = plan[i].vs && !prev_vs;
            was_open = open;
            emit     = 0;
            if (prev_emit && (rise || !plan[i].act)) exp_q[exp_q.size()-1].l = 1'b1;
            if (rise) begin
                open = 1;
                sof  = 1;
                fidx++;
                kept = 0;
            end
            if (plan[i].act && was_open) begin
                if (fidx == cap_frame && kept == DEPTH) begin
                    open    = 0;
                    exp_ovf = 1;
                end else begin
                    exp_q.push_back('{plan[i].d, sof, 1'b0});
                    sof  = 0;
                    kept++;
                    emit = 1;
                end
            end
            prev_emit = emit;
            prev_vs   = plan[i].vs;
        end
    endfunction

    function automatic int first_diff();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].u !== exp_q[i].u ||
                obs_q[i].l !== exp_q[i].l) return i;
        end
        return (obs_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    task automatic run_plan();
        logic [DW+1:0] saved = '0;
        bit stalled = 0;
        foreach (plan[i]) begin
            @(negedge clk);
            in_vsync    = plan[i].vs;
            in_active   = plan[i].act;
            in_hsync    = plan[i].act;
            in_data     = plan[i].d;
            axis.tready = plan[i].rdy;
            if (stalled && (!axis.tvalid || {axis.tuser, axis.tlast, axis.tdata} !== saved))
                stall_bad++;
            if (axis.tvalid && axis.tready) obs_q.push_back('{axis.tdata, axis.tuser, axis.tlast});
            stalled = axis.tvalid && !axis.tready;
            if (stalled) stall_cnt++;
            saved = {axis.tuser, axis.tlast, axis.tdata};
        end
        plan.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_vsync = 1'b0; in_active = 1'b0; in_hsync = 1'b0; in_data = '0;
        axis.tready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); obs_q.delete(); plan.delete();
        cap_frame = -1; exp_ovf = 0; stall_bad = 0; stall_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (axis.tvalid !== 1'b0) begin n_bad++;
            $display("FAIL reset.tvalid: got %b, required 0", axis.tvalid); end
        n_cmp++; if (axis.tuser !== 1'b0) begin n_bad++;
            $display("FAIL reset.tuser: got %b, required 0", axis.tuser); end
        n_cmp++; if (axis.tlast !== 1'b0) begin n_bad++;
            $display("FAIL reset.tlast: got %b, required 0", axis.tlast); end
        n_cmp++; if (axis.tdata !== '0) begin n_bad++;
            $display("FAIL reset.tdata: got %h, required 0", axis.tdata); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++;
            $display("FAIL reset.overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_two_frames();
        int d, nu = 0;
        do_reset();
        add_idle(8, 0);
        add_frame(4, 1280, 20, 0);
        add_frame(4, 1280, 20, 0);
        add_idle(64, 0);
        build_expected();
        run_plan();
        foreach (obs_q[i]) if (obs_q[i].u) nu++;
        d = first_diff();
        n_cmp++; if (d != -1) begin n_bad++;
            $display("FAIL two_frames.beats: first diff at beat %0d, got %0d beats, required %0d",
                     d, obs_q.size(), exp_q.size()); end
        n_cmp++; if (obs_q.size() != 10240) begin n_bad++;
            $display("FAIL two_frames.count: got %0d, required 10240", obs_q.size()); end
        n_cmp++; if (nu != 2) begin n_bad++;
            $display("FAIL two_frames.tuser_count: got %0d, required 2", nu); end
        n_cmp++; if (overflow !== exp_ovf) begin n_bad++;
            $display("FAIL two_frames.overflow: got %b, required %b", overflow, exp_ovf); end
    endtask

    task automatic test_pre_sof();
        int d, k = 0;
        logic [DW-1:0] first_d;
        do_reset();
        add_frame(1, 10, 4, 1);
        run_plan();
        n_cmp++; if (axis.tvalid !== 1'b1) begin n_bad++;
            $display("FAIL pre_sof.stalled_valid: got %b, required 1", axis.tvalid); end
        do_reset();
        n_cmp++; if (axis.tvalid !== 1'b0) begin n_bad++;
            $display("FAIL pre_sof.reset_flush: got %b, required 0", axis.tvalid); end
        add_line(50, 10, 0);
        add_line(50, 10, 0);
        add_frame(2, 40, 10, 0);
        add_idle(64, 0);
        while (k < plan.size() && !plan[k].vs) k++;
        while (k < plan.size() && !plan[k].act) k++;
        first_d = plan[k].d;
        build_expected();
        run_plan();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_bad++;
            $display("FAIL pre_sof.beats: first diff at beat %0d, got %0d beats, required %0d",
                     d, obs_q.size(), exp_q.size()); end
        n_cmp++; if (obs_q.size() == 0 || obs_q[0].d !== first_d || obs_q[0].u !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_sof.first_beat: got %0d beats, required first data %h with tuser",
                     obs_q.size(), first_d); end
    endtask

    task automatic test_overflow();
        int d;
        do_reset();
        cap_frame = 0;
        add_idle(4, 0);
        add_frame(2, 1280, 20, 1);
        add_idle(100, 0);
        add_frame(2, 1280, 20, 0);
        add_idle(64, 0);
        build_expected();
        run_plan();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_bad++;
            $display("FAIL overflow.beats: first diff at beat %0d, got %0d beats, required %0d",
                     d, obs_q.size(), exp_q.size()); end
        n_cmp++; if (obs_q.size() != DEPTH + 2560) begin n_bad++;
            $display("FAIL overflow.count: got %0d, required %0d", obs_q.size(), DEPTH + 2560); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++;
            $display("FAIL overflow.flag: got %b, required 1", overflow); end
        n_cmp++; if (obs_q.size() <= DEPTH || obs_q[DEPTH].u !== 1'b1) begin n_bad++;
            $display("FAIL overflow.next_sof: got %0d beats, required tuser on beat %0d",
                     obs_q.size(), DEPTH); end
    endtask

    task automatic test_stall_toggle();
        int d;
        do_reset();
        repeat (2) begin
            add_vsync(2);
            repeat (6) add_line($urandom_range(8, 20), 100, 2);
        end
        add_idle(64, 0);
        build_expected();
        run_plan();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_bad++;
            $display("FAIL stall.beats: first diff at beat %0d, got %0d beats, required %0d",
                     d, obs_q.size(), exp_q.size()); end
        n_cmp++; if (stall_bad != 0) begin n_bad++;
            $display("FAIL stall.stable: got %0d unstable stall cycles, required 0", stall_bad); end
        n_cmp++; if (stall_cnt == 0) begin n_bad++;
            $display("FAIL stall.exercised: got %0d stall cycles, required > 0", stall_cnt); end
        n_cmp++; if (overflow !== exp_ovf) begin n_bad++;
            $display("FAIL stall.overflow: got %b, required %b", overflow, exp_ovf); end
    endtask

    task automatic test_midline_vsync();
        int d;
        do_reset();
        add_vsync(0);
        add_line(1280, 20, 0);
        repeat (500) add_cyc(1'b0, 1'b1, 0);
        repeat (3) add_cyc(1'b1, 1'b1, 0);
        repeat (97) add_cyc(1'b0, 1'b1, 0);
        add_idle(20, 0);
        add_line(100, 20, 0);
        add_idle(64, 0);
        build_expected();
        run_plan();
        d = first_diff();
        n_cmp++; if (d != -1) begin n_bad++;
            $display("FAIL midline.beats: first diff at beat %0d, got %0d beats, required %0d",
                     d, obs_q.size(), exp_q.size()); end
        n_cmp++; if (obs_q.size() < 1781 || obs_q[1779].l !== 1'b1 || obs_q[1780].u !== 1'b1)
        begin
            n_bad++;
            $display("FAIL midline.cut: got %0d beats, required tlast on 1779 and tuser on 1780",
                     obs_q.size()); end
    endtask

`ifdef OV5640_AXIS_STATS_EN
    task automatic test_stats();
        do_reset();
        repeat (3) add_frame(2, 64, 10, 0);
        add_frame(1, 64, 10, 1);
        add_idle(100, 0);
        run_plan();
        n_cmp++; if (frame_cnt !== 16'd4) begin n_bad++;
            $display("FAIL stats.frame_cnt: got %0d, required 4", frame_cnt); end
        n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++;
            $display("FAIL stats.drop_cnt: got %0d, required 1", drop_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_vsync = 1'b0; in_active = 1'b0; in_hsync = 1'b0; in_data = '0;
        axis.tready = 1'b1;
        test_reset();
        test_two_frames();
        test_pre_sof();
        test_overflow();
        test_stall_toggle();
        test_midline_vsync();
`ifdef OV5640_AXIS_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
